// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'h1eceb000;

  typedef logic [31:0] pc_t;

  // Sequential fetch advances one 32-bit instruction word.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_checker.sv
// Interface checker for fetch_ctrl: a response may only arrive while a
// request is actually in flight.
module fetch_ctrl_checker #(
  parameter int OW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_resp_i,
  input logic [OW-1:0] outstanding_i
);

  a_resp_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst) imem_resp_i |-> (outstanding_i != {OW{1'b0}})
  );

endmodule

// File: rtl/fetch_pc_fifo.sv
// Circular FIFO that remembers the address of every in-flight imem request,
// so each in-order response can be tagged with its PC.
module fetch_pc_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  pc_t  push_data_i,
  input  logic pop_i,
  output pc_t  head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  pc_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;

  // Wrap explicitly so a non-power-of-two depth would still be correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {AW{1'b0}};
    end else begin
      return ptr + {{(AW-1){1'b0}}, 1'b1};
    end
  endfunction

  assign head_o = mem_q[rd_ptr_q];

  // Pointer and storage update; push and pop in the same cycle are independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC generation, credit-gated imem requests,
// in-order response forwarding to the instruction queue, redirect draining.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_credit_stall counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          IQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        iq_pop,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        iq_push,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  output logic        iq_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_credit_stall
`endif
);

  localparam int CW = $clog2(IQ_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(IQ_DEPTH);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);

  fetch_state_t  state_q, state_d;
  pc_t           pc_q, pc_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] out_after_resp_s;
  logic          issue_s;
  logic          accept_s;
  pc_t           fifo_head_s;

  // One credit out, up to one credit back; clamp guards against stray pops.
  function automatic logic [CW-1:0] credit_step(input logic [CW-1:0] cr,
                                                input logic dec,
                                                input logic inc);
    logic [CW:0] sum;
    sum = {1'b0, cr} + {{CW{1'b0}}, inc} - {{CW{1'b0}}, dec};
    if (sum > {1'b0, CRED_MAX}) begin
      return CRED_MAX;
    end else begin
      return sum[CW-1:0];
    end
  endfunction

  // Issue and accept depend only on registered counters plus the redirect input.
  always_comb begin
    issue_s  = !rst && (state_q == RUN) && !redirect_valid &&
               (credits_q != {CW{1'b0}}) && (out_q < MAX_OUT_C);
    accept_s = !rst && imem_resp && (state_q == RUN) && !redirect_valid;
  end

  assign imem_addr  = pc_q;
  assign imem_rmask = issue_s ? 4'hF : 4'h0;
  assign iq_push    = accept_s;
  assign iq_instr   = accept_s ? imem_rdata : 32'h0;
  assign iq_pc      = accept_s ? fifo_head_s : 32'h0;
  assign iq_flush   = redirect_valid;

  fetch_pc_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (issue_s),
    .push_data_i(pc_q),
    .pop_i      (imem_resp),
    .head_o     (fifo_head_s)
  );

  // Next-state logic: redirect overrides everything; DRAIN only retires stale responses.
  always_comb begin
    out_after_resp_s = imem_resp ? (out_q - OW'(1)) : out_q;
    out_d     = out_after_resp_s + (issue_s ? OW'(1) : OW'(0));
    state_d   = state_q;
    pc_d      = pc_q;
    credits_d = credits_q;
    if (redirect_valid) begin
      // The queue is flushed, so every credit not tied to an in-flight request returns.
      pc_d      = redirect_pc;
      credits_d = CRED_MAX - CW'(out_after_resp_s);
      if (out_after_resp_s != {OW{1'b0}}) begin
        state_d = DRAIN;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          state_d   = RUN;
          pc_d      = issue_s ? pc_next(pc_q) : pc_q;
          credits_d = credit_step(credits_q, issue_s, iq_pop);
        end
        DRAIN: begin
          // Queue is empty after the flush, so pops cannot occur; only dropped responses free credits.
          pc_d      = pc_q;
          credits_d = credit_step(credits_q, 1'b0, imem_resp);
          if (imem_resp && (out_q == OW'(1))) begin
            state_d = RUN;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d   = RUN;
          pc_d      = pc_q;
          credits_d = credits_q;
        end
      endcase
    end
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      credits_q <= CRED_MAX;
      out_q     <= {OW{1'b0}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      credits_q <= credits_d;
      out_q     <= out_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;
  logic        stall_s;

  assign stall_s           = (state_q == RUN) && !redirect_valid && (credits_q == {CW{1'b0}});
  assign perf_credit_stall = perf_q;

  // Saturating count of cycles fetch wanted to run but had no queue credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 32'h0;
    end else if (stall_s && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end else begin
      perf_q <= perf_q;
    end
  end
`endif

  fetch_ctrl_checker #(
    .OW(OW)
  ) u_checker (
    .clk          (clk),
    .rst          (rst),
    .imem_resp_i  (imem_resp),
    .outstanding_i(out_q)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl plus hand-written free-run
// and (when built with FETCH_PERF_CNT_EN) stall counter sequences.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        iq_pop = 1'b0;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic        iq_push;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        iq_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_credit_stall;
`endif

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .iq_pop        (iq_pop),
    .imem_addr     (imem_addr),
    .imem_rmask    (imem_rmask),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .iq_push       (iq_push),
    .iq_instr      (iq_instr),
    .iq_pc         (iq_pc),
    .iq_flush      (iq_flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_credit_stall(perf_credit_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        pop;
    logic        resp;
    logic [31:0] rdata;
    logic        ca;     // compare imem_addr on this row
    logic [31:0] addr;
    logic        rm;     // request expected this cycle
    logic        push;
    logic [31:0] ipc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic pop, input logic resp, input logic [31:0] rdata,
                              input logic ca, input logic [31:0] addr, input logic rm,
                              input logic push, input logic [31:0] ipc, input logic [31:0] instr);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.pop = pop; v.resp = resp; v.rdata = rdata;
    v.ca = ca; v.addr = addr; v.rm = rm; v.push = push; v.ipc = ipc; v.instr = instr;
    return v;
  endfunction

  function automatic vec_t rst_row();
    return mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  // Drive one cycle of inputs mid-cycle, then compare combinational outputs before the edge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    logic [3:0] exp_rm;
    logic       bad;
    @(negedge clk);
    rst            = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    iq_pop         = v.pop;
    imem_resp      = v.resp;
    imem_rdata     = v.rdata;
    #1;
    exp_rm = v.rm ? 4'hF : 4'h0;
    bad = (imem_rmask !== exp_rm) || (iq_push !== v.push) || (iq_pc !== v.ipc) ||
          (iq_instr !== v.instr) || (iq_flush !== v.rv) || (v.ca && (imem_addr !== v.addr));
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s[%0d]: got addr=%h rmask=%h push=%b pc=%h instr=%h flush=%b; want addr=%h(chk=%b) rmask=%h push=%b pc=%h instr=%h flush=%b",
               tag, idx, imem_addr, imem_rmask, iq_push, iq_pc, iq_instr, iq_flush,
               v.addr, v.ca, exp_rm, v.push, v.ipc, v.instr, v.rv);
    end
  endtask

  initial begin
    // Reset, then free-run with pops: back-to-back requests, in-order tagging.
    vecs.push_back(rst_row());
    vecs.push_back(rst_row());
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,        1,32'h1eceb000,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,32'hA0000001, 1,32'h1eceb004,1, 1,32'h1eceb000,32'hA0000001));
    vecs.push_back(mk(0,0,32'h0,1,1,32'hA0000002, 1,32'h1eceb008,1, 1,32'h1eceb004,32'hA0000002));
    vecs.push_back(mk(0,0,32'h0,1,1,32'hA0000003, 1,32'h1eceb00c,1, 1,32'h1eceb008,32'hA0000003));
    // Reset mid-run with a request in flight; credits exhaust after 4 requests.
    vecs.push_back(rst_row());
    vecs.push_back(rst_row());
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,        1,32'h1eceb000,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hB0000001, 1,32'h1eceb004,1, 1,32'h1eceb000,32'hB0000001));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hB0000002, 1,32'h1eceb008,1, 1,32'h1eceb004,32'hB0000002));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hB0000003, 1,32'h1eceb00c,1, 1,32'h1eceb008,32'hB0000003));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hB0000004, 1,32'h1eceb010,0, 1,32'h1eceb00c,32'hB0000004));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,        1,32'h1eceb010,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,        1,32'h1eceb010,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,        1,32'h1eceb010,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hB0000008, 1,32'h1eceb014,0, 1,32'h1eceb010,32'hB0000008));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,        1,32'h1eceb014,0, 0,32'h0,32'h0));
    // Redirect with two outstanding: both responses dropped, resume at target.
    vecs.push_back(rst_row());
    vecs.push_back(rst_row());
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h1eceb000,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h1eceb004,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h1eceb008,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,1,32'h1eceb100,0,0,32'h0,   1,32'h1eceb008,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hC0000004,   1,32'h1eceb100,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hC0000005,   1,32'h1eceb100,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h1eceb100,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hC0000007,   1,32'h1eceb104,1, 1,32'h1eceb100,32'hC0000007));
    // Redirect coinciding with the only response: dropped, stay RUN, full 4 credits.
    vecs.push_back(mk(0,1,32'h00004000,0,1,32'hD0000008, 1,32'h1eceb108,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h00004000,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hD000000A,   1,32'h00004004,1, 1,32'h00004000,32'hD000000A));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hD000000B,   1,32'h00004008,1, 1,32'h00004004,32'hD000000B));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hD000000C,   1,32'h0000400c,1, 1,32'h00004008,32'hD000000C));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hD000000D,   1,32'h00004010,0, 1,32'h0000400c,32'hD000000D));
    // Second redirect while draining: the later target wins.
    vecs.push_back(rst_row());
    vecs.push_back(rst_row());
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h1eceb000,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h1eceb004,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,1,32'h1eceb100,0,0,32'h0,   1,32'h1eceb008,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hE0000003,   1,32'h1eceb100,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,1,32'h1eceb200,0,0,32'h0,   1,32'h1eceb100,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hE0000005,   1,32'h1eceb200,0, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h1eceb200,1, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h1eceb204,1, 0,32'h0,32'h0));
    vecs.push_back(rst_row());
    vecs.push_back(rst_row());

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], "vec", i);
    end

    // Free-run: imem answers one cycle after each request, pops held high.
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      logic [31:0] a;
      logic [31:0] pa;
      a  = 32'h1eceb000 + 32'(4 * i);
      pa = a - 32'd4;
      if (i == 0) begin
        v = mk(0,0,32'h0,1,0,32'h0, 1,a,1, 0,32'h0,32'h0);
      end else begin
        v = mk(0,0,32'h0,1,1,pa ^ 32'h5A5A5A5A, 1,a,1, 1,pa,pa ^ 32'h5A5A5A5A);
      end
      apply(v, "freerun", i);
    end
    apply(rst_row(), "freerun_rst", 0);

`ifdef FETCH_PERF_CNT_EN
    // Exhaust credits, then hold pops low for 10 cycles of credit stall.
    apply(rst_row(), "perf", 0);
    apply(mk(0,0,32'h0,0,0,32'h0,        1,32'h1eceb000,1, 0,32'h0,32'h0), "perf", 1);
    apply(mk(0,0,32'h0,0,1,32'hF0000001, 1,32'h1eceb004,1, 1,32'h1eceb000,32'hF0000001), "perf", 2);
    apply(mk(0,0,32'h0,0,1,32'hF0000002, 1,32'h1eceb008,1, 1,32'h1eceb004,32'hF0000002), "perf", 3);
    apply(mk(0,0,32'h0,0,1,32'hF0000003, 1,32'h1eceb00c,1, 1,32'h1eceb008,32'hF0000003), "perf", 4);
    apply(mk(0,0,32'h0,0,1,32'hF0000004, 1,32'h1eceb010,0, 1,32'h1eceb00c,32'hF0000004), "perf", 5);
    for (int i = 0; i < 9; i++) begin
      apply(mk(0,0,32'h0,0,0,32'h0, 1,32'h1eceb010,0, 0,32'h0,32'h0), "perf_idle", i);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (perf_credit_stall !== 32'd10) begin
      n_bad++;
      $display("FAIL perf_count: got %0d want 10", perf_credit_stall);
    end
    apply(rst_row(), "perf_rst", 0);
    apply(mk(0,0,32'h0,0,0,32'h0, 1,32'h1eceb000,1, 0,32'h0,32'h0), "perf_after_rst", 0);
    n_vec++;
    if (perf_credit_stall !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_reset: got %0d want 0", perf_credit_stall);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch into the instruction queue of the out-of-order core.
- Generates the PC stream and issues pipelined in-order requests to instruction memory.
- Gates requests with a credit counter so the queue can never overflow.
- On a redirect (branch/flush), discards in-flight responses from the old path.
- Sits between the imem port and the instruction queue's push side; the consumer side only returns credits via iq_pop.

Parameters:
- IQ_DEPTH, 4, instruction queue capacity in entries; the initial credit count.
- MAX_OUTSTANDING, 2, maximum imem requests in flight (power of 2, ≥1).
- RESET_PC, 32'h1eceb000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC, word aligned
- iq_pop  in  1  queue consumer removed one entry (returns one credit)
- imem_addr  out  32  request address
- imem_rmask  out  4  4'hF for exactly one cycle per request, else 4'h0
- imem_rdata  in  32  response data
- imem_resp  in  1  response valid; responses return in request order
- iq_push  out  1  push to instruction queue
- iq_instr  out  32  instruction pushed
- iq_pc  out  32  PC of instruction pushed
- iq_flush  out  1  combinational copy of redirect_valid; clears the queue

Behaviour:
- State:
  - pc (32).
  - credits (width $clog2(IQ_DEPTH+1)).
  - outstanding (width $clog2(MAX_OUTSTANDING+1)).
  - FSM {RUN, DRAIN}.
  - PC FIFO of MAX_OUTSTANDING entries holding request addresses.
- Reset values:
  - pc = RESET_PC, credits = IQ_DEPTH, outstanding = 0, state RUN, PC FIFO empty.
  - imem_rmask = 0, iq_push = 0, iq_instr = 0, iq_pc = 0.
- Request issue (combinational, single cycle):
  - Condition: state == RUN && !redirect_valid && credits != 0 && outstanding < MAX_OUTSTANDING, using registered counters only.
  - On issue: imem_addr = pc, imem_rmask = 4'hF, pc is pushed into the PC FIFO.
  - Next cycle: pc ← pc+4, credits −1, outstanding +1.
  - Back-to-back requests every cycle are allowed.
  - When not issuing, imem_addr = pc and imem_rmask = 0.
- Response, RUN and no redirect:
  - Same cycle: iq_push = 1, iq_instr = imem_rdata, iq_pc = PC FIFO head.
  - PC FIFO pops; outstanding −1.
  - Zero-cycle latency, imem_resp → iq_push.
- Credit rule:
  - iq_pop adds one credit.
  - Simultaneous issue and pop: net 0.
  - credits never exceeds IQ_DEPTH; pushes into a full queue are impossible by construction.
- Redirect, any state:
  - iq_flush = 1; no issue that cycle; pc ← redirect_pc.
  - A response arriving the same cycle is dropped: iq_push = 0, FIFO pops, outstanding −1.
  - iq_pop that cycle is ignored.
  - out_n = outstanding after this cycle's response; credits ← IQ_DEPTH − out_n.
  - Next state = DRAIN if out_n > 0, else RUN.
- DRAIN:
  - No requests.
  - Every response is dropped: iq_push = 0, FIFO pops, outstanding −1, credits +1.
  - On the cycle the last response arrives (outstanding 1 → 0), next state is RUN; a request may issue the following cycle.
  - A redirect while in DRAIN applies the redirect rules and stays in DRAIN if out_n > 0.
- Forbidden input: imem_resp with outstanding == 0 is illegal; covered by an assertion.
- Reset mid-operation:
  - All state returns to reset values.
  - In-flight imem responses are the memory's responsibility and are not tracked.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output perf_credit_stall (32), reset 0.
  - Increments each cycle in RUN with !redirect_valid && credits == 0; saturates at 32'hFFFFFFFF.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {RUN, DRAIN}.
  - Localparam FETCH_RESET_PC.
  - Typedef pc_t (logic [31:0]).
- One sub-module: fetch_pc_fifo.
  - Synchronous circular FIFO, depth MAX_OUTSTANDING, width 32.
  - Ports: push, pop, head data, flush-free.
  - Simultaneous push/pop supported.

Test Plan:
- Reset then free-run, imem responds 1 cycle after each request, iq_pop held 1 → requests at 1eceb000, 1eceb004, …, one per cycle in steady state; iq_pc matches each request address in order.
- iq_pop held 0, IQ_DEPTH=4 → exactly 4 requests issued; imem_rmask stays 0 afterwards. Single iq_pop pulse → exactly one further request, the next cycle.
- Two requests outstanding, redirect to 0x1eceb100 → both responses are dropped (iq_push 0). First request after the second response is 0x1eceb100, at the next cycle.
- Redirect in the same cycle as imem_resp with outstanding = 1 → response dropped, FSM stays RUN, request for redirect_pc issues the next cycle, credits = 4.
- Redirect during DRAIN with 1 outstanding, new pc 0x1eceb200 → last response dropped; fetch resumes at 0x1eceb200, not at the first redirect target.
- FETCH_PERF_CNT_EN defined, iq_pop 0 for 10 cycles after credits are exhausted → perf_credit_stall = 10. Reset mid-run → counter 0 and next request at 1eceb000.
